// File: rtl/sum_response_checker_pkg.sv
// Shared definitions for the gated-sum response checker: state codes,
// fill-counter width and the golden model of the gated-sum block.
package sum_response_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Wide enough to hold LAT-1 for the largest supported latency (4).
    localparam int FILL_W = 3;

    // Expected gated-sum output for one stimulus sample.
    function automatic logic gold_sum(input logic en, input logic a, input logic b);
        return en & (a ^ b);
    endfunction

endpackage

// File: rtl/sum_chk_delay.sv
// DEPTH-stage delay line for the predicted response. Runs every clock so the
// pipeline is already aligned with the DUT when comparison starts.
// DEPTH == 0 degenerates to a wire.
module sum_chk_delay #(
    parameter int DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, i_clk, i_rst_n};
        assign o_q = i_d;
    end else begin : g_shift
        logic [DEPTH-1:0] sr_q;

        // Shift the prediction one stage per clock; reset clears every stage.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sr_q <= '0;
            end else begin
                sr_q[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign o_q = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/sum_response_checker.sv
// On-chip checker for the gated-sum block. Predicts each response from the
// stimulus, delays the prediction by LAT clocks and compares it with the DUT
// output over WINDOW samples, reporting error count, first failing index and
// a pass flag.
//
// state | meaning
// IDLE  | waiting for i_start, results cleared
// FILL  | delay line priming for LAT cycles, no compares
// CHECK | one compare per clock, WINDOW compares in total
// DONE  | results held until the next i_start
module sum_response_checker
    import sum_response_checker_pkg::*;
#(
    parameter int LAT    = 1,
    parameter int WINDOW = 20,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_o_sum,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_smp_cnt,
    output logic             o_first_fail_vld,
    output logic [CNT_W-1:0] o_first_fail_idx
);

    state_e             state_q;
    logic [FILL_W-1:0]  fill_cnt_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [CNT_W-1:0]   smp_cnt_q;
    logic [CNT_W-1:0]   first_idx_q;
    logic               first_vld_q;

    logic               exp_now;
    logic               dly_exp;
    logic               mismatch;
    logic               last_smp;

    assign exp_now = gold_sum(i_en, i_a, i_b);

    sum_chk_delay #(
        .DEPTH (LAT)
    ) u_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (exp_now),
        .o_q     (dly_exp)
    );

    assign mismatch = dly_exp ^ i_o_sum;
    assign last_smp = (smp_cnt_q == CNT_W'(WINDOW - 1));

    // Run sequencing, sample/error counting and first-fail capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            fill_cnt_q  <= '0;
            err_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        err_cnt_q   <= '0;
                        smp_cnt_q   <= '0;
                        first_idx_q <= '0;
                        first_vld_q <= 1'b0;
                        // Down-counter: FILL ends on the cycle it reads zero.
                        fill_cnt_q  <= FILL_W'(LAT - 1);
                        state_q     <= (LAT > 0) ? ST_FILL : ST_CHECK;
                    end
                end
                ST_FILL: begin
                    if (fill_cnt_q == '0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        fill_cnt_q <= fill_cnt_q - FILL_W'(1);
                    end
                end
                ST_CHECK: begin
                    smp_cnt_q <= smp_cnt_q + CNT_W'(1);
                    if (mismatch) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + CNT_W'(1);
                        end
                        if (!first_vld_q) begin
                            first_vld_q <= 1'b1;
                            first_idx_q <= smp_cnt_q;
                        end
                    end
                    if (last_smp) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy           = (state_q == ST_FILL) || (state_q == ST_CHECK);
    assign o_done           = (state_q == ST_DONE);
    assign o_pass           = o_done & (err_cnt_q == '0);
    assign o_err_cnt        = err_cnt_q;
    assign o_smp_cnt        = smp_cnt_q;
    assign o_first_fail_vld = first_vld_q;
    assign o_first_fail_idx = first_idx_q;

endmodule

// File: tb/tb_sum_response_checker.sv
`timescale 1ns/1ps
// Bench for sum_response_checker: one LAT=1/WINDOW=20 checker plus two
// CNT_W=3/WINDOW=7 checkers at LAT=0 and LAT=4. Each run pushes its
// hand-computed result; a monitor pops and compares when o_done rises.
module tb_sum_response_checker;

    localparam int LAT0 = 1, W0 = 20, C0 = 16;
    localparam int LAT1 = 0, W1 = 7,  C1 = 3;
    localparam int LAT2 = 4, W2 = 7,  C2 = 3;

    typedef struct {
        int inst;
        int err;
        int smp;
        int vld;
        int idx;
        int pass;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, a = 1'b0, b = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

    // fake DUT controls
    logic flip0 = 1'b0, stuck0 = 1'b0, inv_s = 1'b0, quiet = 1'b0;
    logic g;
    logic p1 = 1'b0;
    logic [3:0] p4 = 4'b0;
    logic sum0, sum1, sum2;

    logic busy0, done0, pass0, vld0;
    logic [C0-1:0] err0, smp0, idx0;
    logic busy1, done1, pass1, vld1;
    logic [C1-1:0] err1, smp1, idx1;
    logic busy2, done2, pass2, vld2;
    logic [C2-1:0] err2, smp2, idx2;

    logic        done_v[3], pass_v[3], vld_v[3];
    logic [15:0] err_v[3], smp_v[3], idx_v[3];
    logic        done_prev[3];

    int   cyc = 0;
    int   tgl = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // stimulus: toggling operands with en=1, or the quiet en=0/a=b=1 pattern
    always @(posedge clk) begin
        #1;
        tgl = tgl + 1;
        if (quiet) begin
            en = 1'b0; a = 1'b1; b = 1'b1;
        end else begin
            en = 1'b1; a = tgl[0]; b = tgl[1];
        end
    end

    // behavioural gated-sum DUTs at latency 0, 1 and 4
    assign g = en & (a ^ b);
    always @(posedge clk) begin
        p1 <= g;
        p4 <= {p4[2:0], g};
    end
    assign sum0 = stuck0 ? 1'b1 : (p1 ^ flip0);
    assign sum1 = g ^ inv_s;
    assign sum2 = p4[3] ^ inv_s;

    sum_response_checker #(.LAT(LAT0), .WINDOW(W0), .CNT_W(C0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_en(en), .i_a(a), .i_b(b),
        .i_o_sum(sum0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
        .o_err_cnt(err0), .o_smp_cnt(smp0), .o_first_fail_vld(vld0),
        .o_first_fail_idx(idx0));

    sum_response_checker #(.LAT(LAT1), .WINDOW(W1), .CNT_W(C1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_en(en), .i_a(a), .i_b(b),
        .i_o_sum(sum1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_cnt(err1), .o_smp_cnt(smp1), .o_first_fail_vld(vld1),
        .o_first_fail_idx(idx1));

    sum_response_checker #(.LAT(LAT2), .WINDOW(W2), .CNT_W(C2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_en(en), .i_a(a), .i_b(b),
        .i_o_sum(sum2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
        .o_err_cnt(err2), .o_smp_cnt(smp2), .o_first_fail_vld(vld2),
        .o_first_fail_idx(idx2));

    assign done_v[0] = done0; assign pass_v[0] = pass0; assign vld_v[0] = vld0;
    assign err_v[0] = err0;   assign smp_v[0] = smp0;   assign idx_v[0] = idx0;
    assign done_v[1] = done1; assign pass_v[1] = pass1; assign vld_v[1] = vld1;
    assign err_v[1] = {13'b0, err1}; assign smp_v[1] = {13'b0, smp1}; assign idx_v[1] = {13'b0, idx1};
    assign done_v[2] = done2; assign pass_v[2] = pass2; assign vld_v[2] = vld2;
    assign err_v[2] = {13'b0, err2}; assign smp_v[2] = {13'b0, smp2}; assign idx_v[2] = {13'b0, idx2};

    initial begin
        if (W0 > (1 << C0) - 1 || W1 > (1 << C1) - 1 || W2 > (1 << C2) - 1) begin
            $display("FAIL window_fits: WINDOW exceeds 2^CNT_W-1");
            $fatal(1);
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // monitor: on each rising o_done pop the oldest expectation and compare
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_v[k] && !done_prev[k]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done inst=%0d cycle=%0d", k, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("inst", k, mon_e.inst);
                    chk("done_cycle", cyc, mon_e.done_cyc);
                    chk("err_cnt", int'(err_v[k]), mon_e.err);
                    chk("smp_cnt", int'(smp_v[k]), mon_e.smp);
                    chk("first_fail_vld", int'(vld_v[k]), mon_e.vld);
                    chk("first_fail_idx", int'(idx_v[k]), mon_e.idx);
                    chk("pass", int'(pass_v[k]), mon_e.pass);
                end
            end
            done_prev[k] = done_v[k];
        end
    end

    // pulse i_start of one instance; s is the cycle number after the sampling edge
    task automatic start_run(input int inst, input int lat, input int w, input int e_err,
                             input int e_vld, input int e_idx, input bit push, output int s);
        exp_t e;
        @(posedge clk); #1;
        case (inst)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        s = cyc;
        if (push) begin
            e.inst = inst; e.err = e_err; e.smp = w; e.vld = e_vld; e.idx = e_idx;
            e.pass = (e_err == 0) ? 1 : 0; e.done_cyc = s + lat + w;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_busy"}, int'(busy0), 0);
        chk({tag, "_done"}, int'(done0), 0);
        chk({tag, "_pass"}, int'(pass0), 0);
        chk({tag, "_err"},  int'(err0), 0);
        chk({tag, "_smp"},  int'(smp0), 0);
        chk({tag, "_vld"},  int'(vld0), 0);
        chk({tag, "_idx"},  int'(idx0), 0);
    endtask

    initial begin
        int s;
        for (int k = 0; k < 3; k++) done_prev[k] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_zero0("reset");

        // 1: correct DUT, toggling operands
        start_run(0, LAT0, W0, 0, 0, 0, 1'b1, s);
        repeat (4) @(posedge clk);
        #1;
        chk("midrun_busy", int'(busy0), 1);
        chk("midrun_pass", int'(pass0), 0);
        wait_done(60);

        // 2: response inverted on compare index 5 only
        start_run(0, LAT0, W0, 1, 1, 5, 1'b1, s);
        repeat (LAT0 + 5) @(posedge clk);
        #1; flip0 = 1'b1;
        @(posedge clk);
        #1; flip0 = 1'b0;
        wait_done(60);

        // 3: en=0, a=b=1, DUT stuck at 1
        quiet = 1'b1; stuck0 = 1'b1;
        start_run(0, LAT0, W0, 20, 1, 0, 1'b1, s);
        wait_done(60);
        quiet = 1'b0; stuck0 = 1'b0;

        // 4: restart from DONE clears results; a mid-CHECK start is ignored
        start_run(0, LAT0, W0, 0, 0, 0, 1'b1, s);
        chk("restart_err", int'(err0), 0);
        chk("restart_smp", int'(smp0), 0);
        chk("restart_vld", int'(vld0), 0);
        chk("restart_done", int'(done0), 0);
        chk("restart_busy", int'(busy0), 1);
        repeat (LAT0 + 7) @(posedge clk);
        #1; start0 = 1'b1;
        @(posedge clk);
        #1; start0 = 1'b0;
        chk("ignored_start_smp", int'(smp0), 8);
        wait_done(60);

        // 5: reset pulse mid-CHECK, then a clean run
        quiet = 1'b1; stuck0 = 1'b1;
        start_run(0, LAT0, W0, 0, 0, 0, 1'b0, s);
        repeat (LAT0 + 4) @(posedge clk);
        #1;
        chk("pre_reset_err", int'(err0), 4);
        rst_n = 1'b0;
        #0.5;
        chk_zero0("async_reset");
        #0.5;
        rst_n = 1'b1;
        quiet = 1'b0; stuck0 = 1'b0;
        chk("post_reset_busy", int'(busy0), 0);
        start_run(0, LAT0, W0, 0, 0, 0, 1'b1, s);
        wait_done(60);

        // 6: LAT=0 / LAT=4, CNT_W=3, WINDOW=7; clean runs, then all mismatches
        start_run(1, LAT1, W1, 0, 0, 0, 1'b1, s);
        wait_done(30);
        start_run(2, LAT2, W2, 0, 0, 0, 1'b1, s);
        wait_done(30);
        inv_s = 1'b1;
        start_run(1, LAT1, W1, 7, 1, 0, 1'b1, s);
        wait_done(30);
        start_run(2, LAT2, W2, 7, 1, 0, 1'b1, s);
        wait_done(30);
        inv_s = 1'b0;

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
